// File: rtl/rr_stream_mux.sv
// -----------------------------------------------------------------------------
// rr_stream_mux
//
// Many-to-one valid/ready stream merger. It collects elements from NUM_ELEM
// independent input channels and forwards at most one per cycle into a
// single registered output slot, tagged with the index of the source channel.
// The output slot refills in the same cycle it drains, so a continuously
// ready consumer sees one element per cycle with no bubbles.
//
// Build option:
//   RR_STREAM_MUX_FAIR_EN  defined   -> round-robin arbitration. A pointer
//                                       remembers the last granted channel
//                                       and the search starts just after it.
//                          undefined -> fixed priority. The lowest-index valid
//                                       channel wins, and no pointer exists.
//
// Parameters:
//   NUM_ELEM    number of input channels (>= 2)
//   ELEM_WIDTH  width of one data element
//
// Ports:
//   clk_i     in   clock, rising edge
//   arst_ni   in   asynchronous active-low reset
//   data_i    in   [NUM_ELEM-1:0][ELEM_WIDTH-1:0] per-channel data
//   valid_i   in   [NUM_ELEM-1:0] per-channel valid
//   ready_o   out  [NUM_ELEM-1:0] per-channel ready (one-hot or zero)
//   data_o    out  [ELEM_WIDTH-1:0] registered selected data
//   index_o   out  [$clog2(NUM_ELEM)-1:0] registered source channel
//   valid_o   out  output slot holds an element
//   ready_i   in   downstream accepts the output this cycle
// -----------------------------------------------------------------------------
module rr_stream_mux #(
    parameter int NUM_ELEM   = 4,
    parameter int ELEM_WIDTH = 8
) (
    input  logic                                 clk_i,
    input  logic                                 arst_ni,
    input  logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0]  data_i,
    input  logic [NUM_ELEM-1:0]                  valid_i,
    output logic [NUM_ELEM-1:0]                  ready_o,
    output logic [ELEM_WIDTH-1:0]                data_o,
    output logic [$clog2(NUM_ELEM)-1:0]          index_o,
    output logic                                 valid_o,
    input  logic                                 ready_i
);

    localparam int IDX_W = $clog2(NUM_ELEM);

    // Output slot registers.
    logic                  valid_q, valid_d;
    logic [ELEM_WIDTH-1:0] data_q,  data_d;
    logic [IDX_W-1:0]      index_q, index_d;

    // Arbiter result.
    logic [NUM_ELEM-1:0]   grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_any;

    // The slot can take a new element when it is empty or being drained now.
    logic                  load;

`ifdef RR_STREAM_MUX_FAIR_EN
    // Last granted channel. Reset to the top channel so the first search
    // after reset begins at channel 0.
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      cand;
`endif

    assign load = !valid_q || ready_i;

    // -------------------------------------------------------------------------
    // Arbiter: looks only at valid_i (and the pointer), never at data_i.
    // -------------------------------------------------------------------------
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
`ifdef RR_STREAM_MUX_FAIR_EN
        cand      = '0;
        // Walk ptr+1, ptr+2, ... wrapping modulo NUM_ELEM; the last candidate
        // is the pointer itself, so a lone requester is always found.
        for (int k = 1; k <= NUM_ELEM; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_ELEM);
            if (!grant_any && valid_i[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
`else
        for (int k = 0; k < NUM_ELEM; k++) begin
            if (!grant_any && valid_i[k]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(k);
            end
        end
`endif
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Gated by reset so no source sees a handshake while the block is held
    // in reset (the slot reads as empty then, which would otherwise open load).
    assign ready_o = grant & {NUM_ELEM{load && arst_ni}};

    // -------------------------------------------------------------------------
    // Next-state for the output slot (and pointer).
    // -------------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        index_d = index_q;
`ifdef RR_STREAM_MUX_FAIR_EN
        ptr_d   = ptr_q;
`endif
        if (load) begin
            // Empty input set clears the slot but leaves data/index as they were.
            valid_d = grant_any;
            if (grant_any) begin
                data_d  = data_i[grant_idx];
                index_d = grant_idx;
`ifdef RR_STREAM_MUX_FAIR_EN
                // Pointer moves only on an accepted transfer, so a requester
                // stalled by downstream keeps its turn.
                ptr_d   = grant_idx;
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
`ifdef RR_STREAM_MUX_FAIR_EN
            ptr_q   <= IDX_W'(NUM_ELEM - 1);
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            index_q <= index_d;
`ifdef RR_STREAM_MUX_FAIR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign index_o = index_q;

    // -------------------------------------------------------------------------
    // Protocol properties.
    // -------------------------------------------------------------------------
    a_ready_onehot0 : assert property (
        @(posedge clk_i) disable iff (!arst_ni) $onehot0(ready_o)
    );

    a_output_hold : assert property (
        @(posedge clk_i) disable iff (!arst_ni)
        (valid_o && !ready_i) |=> (valid_o && $stable(data_o) && $stable(index_o))
    );

endmodule

// File: tb/tb_rr_stream_mux.sv
module tb_rr_stream_mux;

   localparam int N = 4;
   localparam int W = 8;

   logic                clk_i;
   logic                arst_ni;
   logic [N-1:0][W-1:0] data_i;
   logic [N-1:0]        valid_i;
   logic [N-1:0]        ready_o;
   logic [W-1:0]        data_o;
   logic [1:0]          index_o;
   logic                valid_o;
   logic                ready_i;

   int checks_total;
   int checks_passed;

   rr_stream_mux #(.NUM_ELEM(N), .ELEM_WIDTH(W)) dut (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .data_i  (data_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_o  (data_o),
      .index_o (index_o),
      .valid_o (valid_o),
      .ready_i (ready_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      if (obs === exp) checks_passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      int e;
      checks_total  = 0;
      checks_passed = 0;

      arst_ni = 1'b0;
      valid_i = 4'b1111;
      ready_i = 1'b1;
      for (int k = 0; k < N; k++) data_i[k] = 8'(8'h10 + k);
      @(negedge clk_i);
      check("reset valid_o", valid_o, 1'b0);
      check("reset data_o",  data_o,  8'h00);
      check("reset index_o", index_o, 2'd0);
      check("reset ready_o", ready_o, 4'b0000);
      valid_i = 4'b0000;
      arst_ni = 1'b1;
      @(negedge clk_i);
      check("idle valid_o", valid_o, 1'b0);

      data_i[2] = 8'hA5;
      valid_i   = 4'b0100;
      #1;
      check("single ready_o", ready_o, 4'b0100);
      @(negedge clk_i);
      check("single valid_o", valid_o, 1'b1);
      check("single data_o",  data_o,  8'hA5);
      check("single index_o", index_o, 2'd2);
      valid_i = 4'b0000;
      @(negedge clk_i);
      check("drain valid_o", valid_o, 1'b0);
      check("drain data_o hold",  data_o,  8'hA5);
      check("drain index_o hold", index_o, 2'd2);

      for (int k = 0; k < N; k++) data_i[k] = 8'(8'hC0 + k);
      valid_i = 4'b1111;
      for (int i = 0; i < 8; i++) begin
`ifdef RR_STREAM_MUX_FAIR_EN
         e = (3 + i) % 4;
`else
         e = 0;
`endif
         #1;
         check("sat ready_o", ready_o, 4'(4'b0001 << e));
         @(negedge clk_i);
         check("sat valid_o", valid_o, 1'b1);
         check("sat index_o", index_o, 2'(e));
         check("sat data_o",  data_o,  8'(8'hC0 + e));
      end
      valid_i = 4'b0000;
      @(negedge clk_i);
      check("sat drain valid_o", valid_o, 1'b0);

      data_i[0] = 8'h30;
      data_i[1] = 8'h31;
      valid_i   = 4'b0011;
      #1;
      check("bp c1 ready_o", ready_o, 4'b0001);
      @(negedge clk_i);
      check("bp c1 index_o", index_o, 2'd0);
      check("bp c1 data_o",  data_o,  8'h30);
      valid_i = 4'b0010;
      ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp stall ready_o", ready_o, 4'b0000);
         @(negedge clk_i);
         check("bp stall valid_o", valid_o, 1'b1);
         check("bp stall index_o", index_o, 2'd0);
         check("bp stall data_o",  data_o,  8'h30);
      end
      ready_i = 1'b1;
      #1;
      check("bp c5 ready_o", ready_o, 4'b0010);
      @(negedge clk_i);
      check("bp c5 valid_o", valid_o, 1'b1);
      check("bp c5 index_o", index_o, 2'd1);
      check("bp c5 data_o",  data_o,  8'h31);
      valid_i = 4'b0000;
      @(negedge clk_i);
      check("bp drain valid_o", valid_o, 1'b0);

      data_i[3] = 8'h43;
      data_i[0] = 8'h40;
      valid_i   = 4'b1000;
      #1;
      check("wrap g3 ready_o", ready_o, 4'b1000);
      @(negedge clk_i);
      check("wrap g3 index_o", index_o, 2'd3);
      valid_i = 4'b1001;
      #1;
      check("wrap ready_o", ready_o, 4'b0001);
      @(negedge clk_i);
      check("wrap index_o", index_o, 2'd0);
      check("wrap data_o",  data_o,  8'h40);
`ifdef RR_STREAM_MUX_FAIR_EN
      e = 3;
`else
      e = 0;
`endif
      #1;
      check("wrap next ready_o", ready_o, 4'(4'b0001 << e));
      @(negedge clk_i);
      check("wrap next index_o", index_o, 2'(e));
      valid_i = 4'b0000;
      @(negedge clk_i);

      data_i[2] = 8'h52;
      valid_i   = 4'b0100;
      ready_i   = 1'b0;
      @(negedge clk_i);
      check("mid held valid_o", valid_o, 1'b1);
      check("mid held index_o", index_o, 2'd2);
      arst_ni = 1'b0;
      valid_i = 4'b1111;
      #1;
      check("mid rst valid_o", valid_o, 1'b0);
      check("mid rst index_o", index_o, 2'd0);
      check("mid rst data_o",  data_o,  8'h00);
      check("mid rst ready_o", ready_o, 4'b0000);
      @(negedge clk_i);
      arst_ni = 1'b1;
      ready_i = 1'b1;
      for (int k = 0; k < N; k++) data_i[k] = 8'(8'h60 + k);
      #1;
      check("post rst ready_o", ready_o, 4'b0001);
      @(negedge clk_i);
      check("post rst valid_o", valid_o, 1'b1);
      check("post rst index_o", index_o, 2'd0);
      check("post rst data_o",  data_o,  8'h60);
      valid_i = 4'b0000;
      @(negedge clk_i);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
